// File: rtl/varray_run_packer.sv
// Run-length packer feeding the virtual-array queue: merges consecutive equal
// elements at contiguous addresses into (start, len, element) queue writes.
module varray_run_packer #(
    parameter int VIRTUAL_ELEMENT_WIDTH = 18,
    parameter int VIRTUAL_ADDR_BITS     = 16,
    parameter int MAX_RUN               = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [VIRTUAL_ADDR_BITS-1:0]     in_addr,
    input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] in_dat,
    input  logic                             flush,
    input  logic                             queue_almost_full,
    output logic                             out_we,
    output logic [VIRTUAL_ADDR_BITS-1:0]     out_write_addr,
    output logic [4:0]                       out_write_addr_len,
    output logic [VIRTUAL_ELEMENT_WIDTH-1:0] out_dat_w,
    output logic                             busy,
    output logic                             order_err
);

    localparam int VAB = VIRTUAL_ADDR_BITS;
    localparam int VEW = VIRTUAL_ELEMENT_WIDTH;
    localparam logic [4:0] MAX_LEN = 5'(MAX_RUN);

    typedef enum logic [1:0] {EMPTY, OPEN, DRAIN} state_t;

    state_t state, state_nxt;

    logic [VAB-1:0] run_start;
    logic [4:0]     run_len;
    logic [VEW-1:0] run_dat;
    logic [VAB:0]   last_end;

    logic           accept, legal, bad, extend, fl;
    logic [VAB:0]   run_end, bound;
    logic [4:0]     len_inc;

    logic           emit, load, grow;
    logic [VAB-1:0] emit_addr;
    logic [4:0]     emit_len;
    logic [VEW-1:0] emit_dat;

    assign in_ready = !reset && !queue_almost_full && (state != DRAIN);
    assign busy     = (state != EMPTY);
    assign accept   = in_valid && in_ready;
    assign fl       = flush && !queue_almost_full;
    assign run_end  = {1'b0, run_start} + (VAB+1)'(run_len);
    assign len_inc  = run_len + 5'd1;

    // While a run is open the next address must lie past it; otherwise past
    // the last emitted run. All-ones is reserved so run ends never wrap.
    assign bound  = (state == OPEN) ? run_end : last_end;
    assign legal  = accept && !({1'b0, in_addr} < bound) && !(&in_addr);
    assign bad    = accept && !legal;
    assign extend = (state == OPEN) && legal && ({1'b0, in_addr} == run_end)
                    && (in_dat == run_dat) && (run_len < MAX_LEN);

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (legal) begin
                    if (MAX_RUN == 1) state_nxt = EMPTY;
                    else if (fl)      state_nxt = DRAIN;
                    else              state_nxt = OPEN;
                end
            end
            OPEN: begin
                if (extend) begin
                    if (len_inc == MAX_LEN || fl) state_nxt = EMPTY;
                end else if (legal) begin
                    state_nxt = fl ? DRAIN : OPEN;
                end else if (fl) begin
                    state_nxt = EMPTY;
                end
            end
            DRAIN: begin
                if (!queue_almost_full) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        emit      = 1'b0;
        load      = 1'b0;
        grow      = 1'b0;
        emit_addr = run_start;
        emit_len  = run_len;
        emit_dat  = run_dat;
        unique case (state)
            EMPTY: begin
                if (legal) begin
                    load = 1'b1;
                    if (MAX_RUN == 1) begin
                        emit      = 1'b1;
                        emit_addr = in_addr;
                        emit_len  = 5'd1;
                        emit_dat  = in_dat;
                    end
                end
            end
            OPEN: begin
                if (extend) begin
                    grow = 1'b1;
                    if (len_inc == MAX_LEN || fl) begin
                        emit     = 1'b1;
                        emit_len = len_inc;
                    end
                end else if (legal) begin
                    emit = 1'b1;
                    load = 1'b1;
                end else if (fl) begin
                    emit = 1'b1;
                end
            end
            DRAIN: begin
                if (!queue_almost_full) emit = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_we             <= 1'b0;
            out_write_addr     <= '0;
            out_write_addr_len <= '0;
            out_dat_w          <= '0;
            order_err          <= 1'b0;
            last_end           <= '0;
            run_start          <= '0;
            run_len            <= '0;
            run_dat            <= '0;
        end else begin
            out_we <= emit;
            if (emit) begin
                out_write_addr     <= emit_addr;
                out_write_addr_len <= emit_len;
                out_dat_w          <= emit_dat;
                last_end           <= {1'b0, emit_addr} + (VAB+1)'(emit_len);
            end
            if (bad) order_err <= 1'b1;
            if (load) begin
                run_start <= in_addr;
                run_len   <= 5'd1;
                run_dat   <= in_dat;
            end else if (grow) begin
                run_len <= len_inc;
            end
        end
    end

endmodule

// File: tb/tb_varray_run_packer.sv
// Directed checks for varray_run_packer with hand-computed run emissions.
module tb_varray_run_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_addr;
    logic [17:0] in_dat;
    logic        flush;
    logic        queue_almost_full;
    logic        out_we;
    logic [15:0] out_write_addr;
    logic [4:0]  out_write_addr_len;
    logic [17:0] out_dat_w;
    logic        busy;
    logic        order_err;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [17:0] DA = 18'h2AAAA;
    localparam logic [17:0] DB = 18'h15555;

    always #5 clk = ~clk;

    varray_run_packer dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_addr            (in_addr),
        .in_dat             (in_dat),
        .flush              (flush),
        .queue_almost_full  (queue_almost_full),
        .out_we             (out_we),
        .out_write_addr     (out_write_addr),
        .out_write_addr_len (out_write_addr_len),
        .out_dat_w          (out_dat_w),
        .busy               (busy),
        .order_err          (order_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [15:0] a,
                       input logic [17:0] d, input logic f);
        in_valid = v;
        in_addr  = a;
        in_dat   = d;
        flush    = f;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic em(input string tag, input logic [15:0] a,
                      input logic [4:0] l, input logic [17:0] d);
        chk({tag, " we"}, 32'(out_we), 32'd1);
        chk({tag, " addr"}, 32'(out_write_addr), 32'(a));
        chk({tag, " len"}, 32'(out_write_addr_len), 32'(l));
        chk({tag, " dat"}, 32'(out_dat_w), 32'(d));
    endtask

    task automatic none(input string tag);
        chk({tag, " no we"}, 32'(out_we), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        in_valid          = 1'b0;
        in_addr           = '0;
        in_dat            = '0;
        flush             = 1'b0;
        queue_almost_full = 1'b0;
        tick();
        tick();
        chk("rst we", 32'(out_we), 32'd0);
        chk("rst addr", 32'(out_write_addr), 32'd0);
        chk("rst len", 32'(out_write_addr_len), 32'd0);
        chk("rst dat", 32'(out_dat_w), 32'd0);
        chk("rst err", 32'(order_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready", 32'(in_ready), 32'd1);

        // 1: five equal contiguous elements, flushed
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'(i), 18'h3, 1'b0);
            none("t1 acc");
        end
        cyc(1'b0, 16'd0, 18'h0, 1'b1);
        em("t1 flush", 16'd0, 5'd5, 18'h3);
        cyc(1'b0, 16'd0, 18'h0, 1'b0);
        none("t1 after");
        chk("t1 busy", 32'(busy), 32'd0);

        // 2: 20 elements split at MAX_RUN
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 16'(100 + i), 18'h7, 1'b0);
            if (i == 15) em("t2 full", 16'd100, 5'd16, 18'h7);
            else         none("t2 acc");
        end
        chk("t2 busy", 32'(busy), 32'd1);
        cyc(1'b0, 16'd0, 18'h0, 1'b1);
        em("t2 flush", 16'd116, 5'd4, 18'h7);

        // 3: data change and address gap each break the run
        do_reset();
        cyc(1'b1, 16'd10, DA, 1'b0);
        none("t3 a10");
        cyc(1'b1, 16'd11, DB, 1'b0);
        em("t3 brk1", 16'd10, 5'd1, DA);
        cyc(1'b1, 16'd15, DB, 1'b0);
        em("t3 brk2", 16'd11, 5'd1, DB);
        cyc(1'b0, 16'd0, 18'h0, 1'b0);
        none("t3 idle");
        cyc(1'b0, 16'd0, 18'h0, 1'b1);
        em("t3 flush", 16'd15, 5'd1, DB);

        // 4: flush with a breaking accept drains the new run next cycle
        do_reset();
        cyc(1'b1, 16'd5, 18'h9, 1'b0);
        cyc(1'b1, 16'd7, 18'h9, 1'b1);
        em("t4 old", 16'd5, 5'd1, 18'h9);
        chk("t4 drain ready", 32'(in_ready), 32'd0);
        cyc(1'b0, 16'd0, 18'h0, 1'b0);
        em("t4 drain", 16'd7, 5'd1, 18'h9);
        chk("t4 busy", 32'(busy), 32'd0);
        chk("t4 ready", 32'(in_ready), 32'd1);
        cyc(1'b0, 16'd0, 18'h0, 1'b0);
        none("t4 after");

        // 4b: flush with an extending accept emits the extended run
        cyc(1'b1, 16'd20, 18'h9, 1'b0);
        cyc(1'b1, 16'd21, 18'h9, 1'b1);
        em("t4b ext", 16'd20, 5'd2, 18'h9);
        chk("t4b busy", 32'(busy), 32'd0);

        // 5: out-of-order and all-ones addresses are dropped
        do_reset();
        cyc(1'b1, 16'd50, 18'h1, 1'b0);
        cyc(1'b1, 16'd49, 18'h1, 1'b0);
        none("t5 drop");
        chk("t5 err", 32'(order_err), 32'd1);
        cyc(1'b0, 16'd0, 18'h0, 1'b0);
        chk("t5 err sticky", 32'(order_err), 32'd1);
        cyc(1'b0, 16'd0, 18'h0, 1'b1);
        em("t5 flush", 16'd50, 5'd1, 18'h1);
        cyc(1'b1, 16'hFFFF, 18'h1, 1'b0);
        none("t5 ones");
        chk("t5 ones busy", 32'(busy), 32'd0);
        chk("t5 err held", 32'(order_err), 32'd1);
        do_reset();
        chk("t5 err clr", 32'(order_err), 32'd0);

        // 6: DRAIN held under backpressure
        cyc(1'b1, 16'd30, 18'h4, 1'b0);
        cyc(1'b1, 16'd40, 18'h4, 1'b1);
        em("t6 old", 16'd30, 5'd1, 18'h4);
        queue_almost_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'd41, 18'h4, 1'b0);
            none("t6 hold");
            chk("t6 hold ready", 32'(in_ready), 32'd0);
            chk("t6 hold busy", 32'(busy), 32'd1);
        end
        queue_almost_full = 1'b0;
        cyc(1'b0, 16'd0, 18'h0, 1'b0);
        em("t6 release", 16'd40, 5'd1, 18'h4);
        cyc(1'b0, 16'd0, 18'h0, 1'b0);
        none("t6 single");
        chk("t6 busy", 32'(busy), 32'd0);

        // 6b: flush ignored under backpressure
        cyc(1'b1, 16'd70, 18'h2, 1'b0);
        queue_almost_full = 1'b1;
        cyc(1'b0, 16'd0, 18'h0, 1'b1);
        none("t6b qaf flush");
        chk("t6b busy", 32'(busy), 32'd1);
        queue_almost_full = 1'b0;
        cyc(1'b0, 16'd0, 18'h0, 1'b1);
        em("t6b flush", 16'd70, 5'd1, 18'h2);

        // 6c: reset while OPEN discards the run
        cyc(1'b1, 16'd80, 18'h5, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        none("t6c rst");
        chk("t6c busy", 32'(busy), 32'd0);
        chk("t6c addr", 32'(out_write_addr), 32'd0);
        chk("t6c len", 32'(out_write_addr_len), 32'd0);
        chk("t6c dat", 32'(out_dat_w), 32'd0);
        cyc(1'b0, 16'd0, 18'h0, 1'b1);
        none("t6c flush");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
